reg_bus_sequencer: RTL and testbench

//  Round-robin controller that shares the tristate data bus of a bank of

---
 rtl/reg_bus_sequencer_if.sv | 40 ++++
 rtl/reg_bus_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_reg_bus_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_sequencer_if.sv
// ============================================================================
//  Module      : reg_bus_sequencer_if
//  Description : Requester-side handshake bundle for reg_bus_sequencer.
//                Carries per-requester request level, direction, register
//                select and write data towards the sequencer, and grant,
//                completion pulse, read result and busy status back.
//                  slave  modport : sequencer view
//                  master modport : requester (control unit / DMA) view
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_bus_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int SEL_W      = 2
) ();

    logic [NUM_REQ-1:0]            req;        // request level, held until done
    logic [NUM_REQ-1:0]            req_we;     // 1 = write, 0 = read
    logic [NUM_REQ*SEL_W-1:0]      req_sel;    // requester i in [i*SEL_W +: SEL_W]
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;  // requester i in [i*DATA_WIDTH +: DATA_WIDTH]
    logic [NUM_REQ-1:0]            gnt;        // one-hot grant, XFER and TURN
    logic [NUM_REQ-1:0]            done;       // one-cycle completion pulse
    logic [DATA_WIDTH-1:0]         rdata;      // last read result
    logic                          busy;       // transaction in flight

    modport slave (
        input  req, req_we, req_sel, req_wdata,
        output gnt, done, rdata, busy
    );

    modport master (
        output req, req_we, req_sel, req_wdata,
        input  gnt, done, rdata, busy
    );

endinterface

`default_nettype wire

// File: rtl/reg_bus_sequencer.sv
// ============================================================================
//  Module      : reg_bus_sequencer
//  Description : Round-robin sequencer sharing one tristate register bus
//                among NUM_REQ requesters. Each grant performs one read or
//                one write to one register: IDLE -> XFER (strobes, 1 cycle)
//                -> TURN (bus released, done pulse, 1 cycle) -> IDLE.
//                All outputs come straight from flops.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-low reset
//                bus    - requester handshake (slave modport)
//                data   - shared register data bus (inout)
//                CS     - per-register chip select
//                WE     - per-register write enable
//                OE     - per-register output enable
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bus_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 4,
    parameter int SEL_W      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    reg_bus_sequencer_if.slave         bus,
    inout  wire [DATA_WIDTH-1:0]       data,
    output logic [NUM_REGS-1:0]        CS,
    output logic [NUM_REGS-1:0]        WE,
    output logic [NUM_REGS-1:0]        OE
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and output flops
    // ------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [PTR_W-1:0]        ptr_q,    ptr_d;     // highest-priority requester
    logic [PTR_W-1:0]        win_q,    win_d;     // current winner
    logic                    op_we_q,  op_we_d;   // latched direction
    logic [SEL_W-1:0]        sel_q,    sel_d;     // latched register select
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;   // latched write data
    logic [NUM_REQ-1:0]      gnt_q,    gnt_d;
    logic [NUM_REQ-1:0]      done_q,   done_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic [NUM_REGS-1:0]     cs_q,     cs_d;
    logic [NUM_REGS-1:0]     we_q,     we_d;
    logic [NUM_REGS-1:0]     oe_q,     oe_d;
    logic                    drive_q,  drive_d;   // bus output enable
    logic                    busy_q,   busy_d;

    // ------------------------------------------------------------------
    // Round-robin arbitration: scan from ptr_q upward, wrapping to 0.
    // ------------------------------------------------------------------
    logic                    arb_found;
    logic [PTR_W-1:0]        arb_idx;
    logic [PTR_W-1:0]        arb_cand;
    logic                    arb_we;
    logic [SEL_W-1:0]        arb_sel;
    logic [DATA_WIDTH-1:0]   arb_wdata;
    logic [NUM_REQ-1:0]      arb_onehot;
    logic [NUM_REGS-1:0]     arb_dec;
    logic [NUM_REQ-1:0]      win_onehot;
    logic [PTR_W-1:0]        ptr_next;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!arb_found && bus.req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Fields of the winning requester
    always_comb begin
        arb_we    = bus.req_we[arb_idx];
        arb_sel   = bus.req_sel[int'(arb_idx)*SEL_W +: SEL_W];
        arb_wdata = bus.req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    // One-hot vectors. The register decoder compares against every legal
    // index, so a select at or beyond NUM_REGS leaves all chip selects low.
    always_comb begin
        arb_onehot = '0;
        win_onehot = '0;
        arb_dec    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == PTR_W'(i)) arb_onehot[i] = 1'b1;
            if (win_q   == PTR_W'(i)) win_onehot[i] = 1'b1;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if (arb_sel == SEL_W'(r)) arb_dec[r] = 1'b1;
        end
    end

    // Pointer moves just past the winner, so the winner ranks last next time
    always_comb begin
        if (win_q == PTR_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_q + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_we_d = op_we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        cs_d    = '0;
        we_d    = '0;
        oe_d    = '0;
        drive_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (arb_found) begin
                    // Fields are latched here so a request dropped during
                    // XFER still completes with its original contents.
                    state_d = ST_XFER;
                    win_d   = arb_idx;
                    op_we_d = arb_we;
                    sel_d   = arb_sel;
                    wdata_d = arb_wdata;
                    gnt_d   = arb_onehot;
                    busy_d  = 1'b1;
                    cs_d    = arb_dec;
                    if (arb_we) begin
                        we_d    = arb_dec;
                        drive_d = 1'b1;
                    end else begin
                        oe_d    = arb_dec;
                    end
                end
            end

            ST_XFER: begin
                // Strobes drop and the bus is released on entry to TURN,
                // which is the turnaround cycle between bus owners.
                state_d = ST_TURN;
                done_d  = win_onehot;
                if (!op_we_q) begin
                    rdata_d = data;
                end
            end

            ST_TURN: begin
                state_d = ST_IDLE;
                ptr_d   = ptr_next;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_we_q <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            cs_q    <= '0;
            we_q    <= '0;
            oe_q    <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_we_q <= op_we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data      = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign CS        = cs_q;
    assign WE        = we_q;
    assign OE        = oe_q;
    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_sequencer.sv
// ============================================================================
//  Module      : tb_reg_bus_sequencer
//  Description : Directed self-checking bench for reg_bus_sequencer with a
//                behavioural four-register bank on the shared bus. The bus
//                is a pulled-down net, so a released bus reads 8'h00.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_bus_sequencer;

    logic       clk;
    logic       reset;
    tri0  [7:0] data;
    logic [3:0] CS;
    logic [3:0] WE;
    logic [3:0] OE;

    int checks   = 0;
    int failures = 0;

    reg_bus_sequencer_if #(.DATA_WIDTH(8), .NUM_REQ(4), .SEL_W(2)) bus ();

    reg_bus_sequencer #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .NUM_REGS   (4),
        .SEL_W      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data),
        .CS    (CS),
        .WE    (WE),
        .OE    (OE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model
    logic [7:0] regs [4];
    logic       rd_en;
    logic [7:0] rd_val;

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (CS[r] && WE[r]) regs[r] <= data;
        end
    end

    always_comb begin
        rd_en  = 1'b0;
        rd_val = 8'h00;
        for (int r = 0; r < 4; r++) begin
            if (OE[r]) begin
                rd_en  = 1'b1;
                rd_val = regs[r];
            end
        end
    end

    assign data = rd_en ? rd_val : 8'bz;

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we, input logic [1:0] sel,
                           input logic [7:0] wd);
        bus.req_we[i]              = we;
        bus.req_sel[i*2 +: 2]      = sel;
        bus.req_wdata[i*8 +: 8]    = wd;
        bus.req[i]                 = 1'b1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        bus.req = '0; bus.req_we = '0; bus.req_sel = '0; bus.req_wdata = '0;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.busy, CS, WE, OE, bus.rdata} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {bus.gnt, bus.done, bus.busy, CS, WE, OE, bus.rdata});
        end
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus_released got=%h want=00", data);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.busy, CS, WE, OE} !== 21'd0) begin
            failures++;
            $display("FAIL idle_no_req got=%h want=0", {bus.gnt, bus.done, bus.busy, CS, WE, OE});
        end
    endtask

    task automatic test_write_read;
        set_req(0, 1'b1, 2'd2, 8'hBF);
        tick();  // XFER
        checks++;
        if ({bus.gnt, bus.busy, CS, WE, OE, bus.done} !== {4'b0001, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000}) begin
            failures++;
            $display("FAIL wr_xfer got=%h want=%h", {bus.gnt, bus.busy, CS, WE, OE, bus.done},
                     {4'b0001, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000});
        end
        checks++;
        if (data !== 8'hBF) begin
            failures++;
            $display("FAIL wr_xfer_data got=%h want=BF", data);
        end
        tick();  // TURN
        checks++;
        if ({bus.gnt, bus.done, bus.busy, CS, WE, OE} !== {4'b0001, 4'b0001, 1'b1, 12'd0}) begin
            failures++;
            $display("FAIL wr_turn got=%h want=%h", {bus.gnt, bus.done, bus.busy, CS, WE, OE},
                     {4'b0001, 4'b0001, 1'b1, 12'd0});
        end
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL wr_turn_released got=%h want=00", data);
        end
        bus.req[0] = 1'b0;
        tick();  // IDLE
        checks++;
        if ({bus.gnt, bus.done, bus.busy} !== 9'd0) begin
            failures++;
            $display("FAIL wr_idle got=%h want=0", {bus.gnt, bus.done, bus.busy});
        end
        set_req(1, 1'b0, 2'd2, 8'h00);
        tick();  // XFER
        checks++;
        if ({bus.gnt, bus.busy, CS, WE, OE} !== {4'b0010, 1'b1, 4'b0100, 4'b0000, 4'b0100}) begin
            failures++;
            $display("FAIL rd_xfer got=%h want=%h", {bus.gnt, bus.busy, CS, WE, OE},
                     {4'b0010, 1'b1, 4'b0100, 4'b0000, 4'b0100});
        end
        tick();  // TURN
        checks++;
        if ({bus.done, bus.rdata} !== {4'b0010, 8'hBF}) begin
            failures++;
            $display("FAIL rd_turn got=%h want=%h", {bus.done, bus.rdata}, {4'b0010, 8'hBF});
        end
        bus.req[1] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'(i), 8'(8'h11 * (i + 1)));
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            logic [7:0] wd;
            oh = 4'b0001 << (k % 4);
            wd = 8'(8'h11 * ((k % 4) + 1));
            tick();  // XFER
            checks++;
            if ({bus.gnt, CS, WE, OE, data} !== {oh, oh, oh, 4'b0000, wd}) begin
                failures++;
                $display("FAIL rr_xfer%0d got=%h want=%h", k, {bus.gnt, CS, WE, OE, data}, {oh, oh, oh, 4'b0000, wd});
            end
            tick();  // TURN
            checks++;
            if ({bus.gnt, bus.done, CS, WE, OE, data} !== {oh, oh, 12'd0, 8'h00}) begin
                failures++;
                $display("FAIL rr_turn%0d got=%h want=%h", k, {bus.gnt, bus.done, CS, WE, OE, data}, {oh, oh, 12'd0, 8'h00});
            end
            if (k == 4) bus.req = '0;
            tick();  // IDLE
        end
    endtask

    task automatic test_priority;
        set_req(2, 1'b1, 2'd0, 8'h5A);
        tick();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL prio_setup_gnt got=%b want=0100", bus.gnt);
        end
        tick();
        bus.req[2] = 1'b0;
        set_req(1, 1'b1, 2'd1, 8'hC1);
        set_req(3, 1'b1, 2'd3, 8'hC3);
        tick();  // IDLE
        tick();  // XFER
        checks++;
        if ({bus.gnt, CS, data} !== {4'b1000, 4'b1000, 8'hC3}) begin
            failures++;
            $display("FAIL prio_first got=%h want=%h", {bus.gnt, CS, data}, {4'b1000, 4'b1000, 8'hC3});
        end
        tick();
        bus.req[3] = 1'b0;
        tick();
        tick();  // XFER
        checks++;
        if ({bus.gnt, CS, data} !== {4'b0010, 4'b0010, 8'hC1}) begin
            failures++;
            $display("FAIL prio_second got=%h want=%h", {bus.gnt, CS, data}, {4'b0010, 4'b0010, 8'hC1});
        end
        tick();
        bus.req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        set_req(3, 1'b1, 2'd1, 8'hAD);
        tick();  // XFER
        checks++;
        if ({bus.gnt, WE} !== {4'b1000, 4'b0010}) begin
            failures++;
            $display("FAIL mid_pre got=%h want=%h", {bus.gnt, WE}, {4'b1000, 4'b0010});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.busy, CS, WE, OE, data} !== 29'd0) begin
            failures++;
            $display("FAIL mid_async_clear got=%h want=0", {bus.gnt, bus.done, bus.busy, CS, WE, OE, data});
        end
        tick();
        checks++;
        if ({bus.done, bus.gnt} !== 8'd0) begin
            failures++;
            $display("FAIL mid_no_done got=%h want=0", {bus.done, bus.gnt});
        end
        set_req(0, 1'b1, 2'd0, 8'h0F);
        reset = 1'b1;
        tick();  // XFER
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_next_grant got=%b want=0001", bus.gnt);
        end
        tick();
        bus.req = '0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [4];
        vals = '{8'h67, 8'h23, 8'h16, 8'hD3};
        set_req(2, 1'b1, 2'd1, vals[0]);
        for (int k = 0; k < 4; k++) begin
            tick();  // XFER
            checks++;
            if ({bus.gnt, WE, data} !== {4'b0100, 4'b0010, vals[k]}) begin
                failures++;
                $display("FAIL b2b_xfer%0d got=%h want=%h", k, {bus.gnt, WE, data}, {4'b0100, 4'b0010, vals[k]});
            end
            if (k == 3) bus.req[2] = 1'b0;
            tick();  // TURN
            checks++;
            if ({bus.done, bus.rdata} !== {4'b0100, 8'h00}) begin
                failures++;
                $display("FAIL b2b_turn%0d got=%h want=%h", k, {bus.done, bus.rdata}, {4'b0100, 8'h00});
            end
            if (k < 3) bus.req_wdata[16 +: 8] = vals[k+1];
            tick();  // IDLE
        end
        set_req(2, 1'b0, 2'd1, 8'h00);
        tick();  // XFER
        checks++;
        if ({OE, WE} !== {4'b0010, 4'b0000}) begin
            failures++;
            $display("FAIL b2b_rd_xfer got=%h want=%h", {OE, WE}, {4'b0010, 4'b0000});
        end
        tick();  // TURN
        checks++;
        if (bus.rdata !== 8'hD3) begin
            failures++;
            $display("FAIL b2b_rdata got=%h want=D3", bus.rdata);
        end
        bus.req[2] = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
